// File: rtl/serial_addsub_pkg.sv
// serial_addsub_pkg: FSM state encoding and counter-width helpers
// shared by the serial add/subtract unit.
`default_nettype none

package serial_addsub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) begin
         result = result + 1;
      end
      return result;
   endfunction

   // The slice counter needs at least one bit even when there is a single slice.
   function automatic int cnt_width(input int nslice);
      return (clog2(nslice) < 1) ? 1 : clog2(nslice);
   endfunction

endpackage

`default_nettype wire

// File: rtl/serial_addsub_fa_cell.sv
// fa_cell: one-bit combinational full adder, the building block of the
// per-cycle ripple chain.
`default_nettype none

module fa_cell (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));

endmodule

`default_nettype wire

// File: rtl/serial_addsub.sv
// serial_addsub: multi-cycle add/subtract unit processing BPC bits per clock,
// LSB slice first, with a start/busy/done handshake.
`default_nettype none

module serial_addsub
   import serial_addsub_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int BPC   = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic             cin,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int NSLICE = WIDTH / BPC;
   localparam int CW     = cnt_width(NSLICE);
   localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

   state_t           state;
   state_t           state_nx;
   logic             load;
   logic             step;
   logic             last;

   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic             carry_reg;
   logic [CW-1:0]    cnt;

   logic [BPC:0]     chain;
   logic [BPC-1:0]   s_bits;
   logic [WIDTH-1:0] res_nx;

   assign chain[0] = carry_reg;
   assign last     = (cnt == LAST);
   assign busy     = (state == RUN);
   assign done     = (state == DONE);

   generate
      for (genvar i = 0; i < BPC; i++) begin : g_fa
         fa_cell u_fa (
            .a  (a_sh[i]),
            .b  (b_sh[i]),
            .ci (chain[i]),
            .s  (s_bits[i]),
            .co (chain[i+1])
         );
      end
   endgenerate

   // Only the upper WIDTH-BPC result bits need storage: the final slice
   // goes straight from the adder chain into the sum register.
   generate
      if (NSLICE > 1) begin : g_multi
         logic [WIDTH-BPC-1:0] part;

         assign res_nx = {s_bits, part};

         always_ff @(posedge clk) begin
            if (rst) begin
               part <= '0;
            end else if (step) begin
               part <= res_nx[WIDTH-1:BPC];
            end
         end
      end else begin : g_single
         assign res_nx = s_bits;
      end
   endgenerate

   always_comb begin
      state_nx = state;
      load     = 1'b0;
      step     = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               load     = 1'b1;
               state_nx = RUN;
            end
         end
         RUN: begin
            step = 1'b1;
            if (last) begin
               state_nx = DONE;
            end
         end
         DONE: begin
            if (start) begin
               load     = 1'b1;
               state_nx = RUN;
            end else begin
               state_nx = IDLE;
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         a_sh      <= '0;
         b_sh      <= '0;
         carry_reg <= 1'b0;
         cnt       <= '0;
         sum       <= '0;
         cout      <= 1'b0;
         ovf       <= 1'b0;
      end else begin
         state <= state_nx;
         if (load) begin
            a_sh      <= a;
            b_sh      <= b ^ {WIDTH{sub}};
            carry_reg <= sub | cin;
            cnt       <= '0;
         end else if (step) begin
            a_sh      <= a_sh >> BPC;
            b_sh      <= b_sh >> BPC;
            carry_reg <= chain[BPC];
            cnt       <= cnt + CW'(1);
            if (last) begin
               sum  <= res_nx;
               cout <= chain[BPC];
               ovf  <= chain[BPC] ^ chain[BPC-1];
            end
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_serial_addsub.sv
// tb_serial_addsub: scoreboard bench over several WIDTH/BPC configurations,
// directed corner cases plus randomized operations against an arithmetic model.
`default_nettype none

module tb_serial_addsub;

   localparam int NCFG = 5;
   localparam int NRAND = 200;

   typedef struct packed {
      logic [31:0] s;
      logic        c;
      logic        o;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int errors   = 0;
   int cfg_done = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   generate
      for (genvar k = 0; k < NCFG; k++) begin : g_cfg
         localparam int W = (k == 4) ? 16 : 8;
         localparam int B = (k == 4) ? 4 : (1 << k);
         localparam int N = W / B;

         logic         rst   = 1'b1;
         logic         start = 1'b0;
         logic         sub   = 1'b0;
         logic         cin   = 1'b0;
         logic [W-1:0] a     = '0;
         logic [W-1:0] b     = '0;
         logic         busy;
         logic         done;
         logic [W-1:0] sum;
         logic         cout;
         logic         ovf;

         exp_t         q[$];
         logic         rst_s = 1'b0;
         logic [31:0]  held  = '0;

         serial_addsub #(.WIDTH(W), .BPC(B)) dut (
            .clk   (clk),
            .rst   (rst),
            .start (start),
            .sub   (sub),
            .cin   (cin),
            .a     (a),
            .b     (b),
            .busy  (busy),
            .done  (done),
            .sum   (sum),
            .cout  (cout),
            .ovf   (ovf)
         );

         // Reference: unsigned and signed integer arithmetic, reduced mod 2^W.
         function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                        input logic s, input logic ci);
            exp_t   e;
            longint lim, ux, uy, sx, sy, r, sr;
            e   = '0;
            lim = longint'(1) << (W - 1);
            ux  = longint'(x);
            uy  = longint'(y);
            sx  = (ux >= lim) ? ux - 2 * lim : ux;
            sy  = (uy >= lim) ? uy - 2 * lim : uy;
            if (s) begin
               r   = ux - uy;
               e.c = (ux >= uy);
               sr  = sx - sy;
            end else begin
               r   = ux + uy + longint'(ci);
               e.c = (r >= 2 * lim);
               sr  = sx + sy + longint'(ci);
            end
            e.s = 32'(r & (2 * lim - 1));
            e.o = (sr >= lim) || (sr < -lim);
            return e;
         endfunction

         always @(posedge clk) rst_s <= rst;

         always @(negedge clk) begin
            if (rst_s) begin
               chk($sformatf("c%0d reset_busy", k), 32'(busy), 32'd0);
               chk($sformatf("c%0d reset_done", k), 32'(done), 32'd0);
               chk($sformatf("c%0d reset_sum", k), 32'(sum), 32'd0);
               chk($sformatf("c%0d reset_cout", k), 32'(cout), 32'd0);
               chk($sformatf("c%0d reset_ovf", k), 32'(ovf), 32'd0);
               held = '0;
            end else if (done) begin
               chk($sformatf("c%0d done_expected", k), 32'(q.size() != 0), 32'd1);
               if (q.size() != 0) begin
                  exp_t e;
                  e = q.pop_front();
                  chk($sformatf("c%0d sum", k), 32'(sum), e.s);
                  chk($sformatf("c%0d cout", k), 32'(cout), 32'(e.c));
                  chk($sformatf("c%0d ovf", k), 32'(ovf), 32'(e.o));
                  held = e.s;
               end
            end else if (busy) begin
               chk($sformatf("c%0d sum_held", k), 32'(sum), held);
            end
         end

         task automatic tick();
            @(posedge clk);
            #1;
         endtask

         task automatic wait_idle();
            int n;
            n = 0;
            while (busy && n < 100) begin
               tick();
               n++;
            end
            chk($sformatf("c%0d idle_timeout", k), 32'(busy), 32'd0);
         endtask

         task automatic wait_done(output int n);
            n = 0;
            while (!done && n < 100) begin
               tick();
               n++;
            end
            chk($sformatf("c%0d done_timeout", k), 32'(done), 32'd1);
         endtask

         task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y,
                              input logic s, input logic ci);
            wait_idle();
            a     = x;
            b     = y;
            sub   = s;
            cin   = ci;
            start = 1'b1;
            q.push_back(model(x, y, s, ci));
            tick();
            start = 1'b0;
         endtask

         initial begin
            logic [W-1:0] ones, maxpos, minneg;
            int n;
            ones   = '1;
            maxpos = ones >> 1;
            minneg = ~maxpos;
            repeat (2) tick();
            rst = 1'b0;
            tick();

            // Latency: busy for cycles 1..N, done in cycle N+1.
            issue(ones, W'(1), 1'b0, 1'b0);
            for (int i = 1; i <= N; i++) begin
               chk($sformatf("c%0d lat_busy%0d", k, i), 32'(busy), 32'd1);
               chk($sformatf("c%0d lat_done%0d", k, i), 32'(done), 32'd0);
               tick();
            end
            chk($sformatf("c%0d lat_done", k), 32'(done), 32'd1);
            chk($sformatf("c%0d lat_busy_off", k), 32'(busy), 32'd0);
            tick();

            issue(maxpos, W'(1), 1'b0, 1'b0);
            issue(minneg, W'(1), 1'b1, 1'b0);
            issue(W'(5), W'(7), 1'b1, 1'b0);
            issue(W'(8'h10), W'(8'h20), 1'b0, 1'b1);
            issue(W'(8'h10), W'(5), 1'b1, 1'b1);
            issue(W'(0), W'(1), 1'b1, 1'b0);

            // Start during RUN must be ignored and leave no second done.
            issue(W'(8'h33), W'(8'h11), 1'b0, 1'b0);
            a     = W'(8'hA5);
            b     = W'(8'h5A);
            sub   = 1'b1;
            start = 1'b1;
            tick();
            start = 1'b0;
            wait_done(n);
            repeat (N + 3) tick();
            chk($sformatf("c%0d ignored_idle", k), 32'(busy), 32'd0);

            // Back-to-back: start in the DONE cycle.
            issue(W'(8'h21), W'(8'h12), 1'b0, 1'b0);
            wait_done(n);
            issue(W'(8'h44), W'(8'h04), 1'b1, 1'b0);
            chk($sformatf("c%0d b2b_busy", k), 32'(busy), 32'd1);
            wait_done(n);
            chk($sformatf("c%0d b2b_latency", k), 32'(n), 32'(N));
            tick();

            // Mid-run reset aborts with no done pulse.
            issue(W'(8'h66), W'(8'h22), 1'b0, 1'b0);
            repeat (((N >= 5) ? 5 : N) - 1) tick();
            rst = 1'b1;
            q.delete();
            tick();
            rst = 1'b0;
            chk($sformatf("c%0d abort_busy", k), 32'(busy), 32'd0);
            repeat (N + 3) tick();
            issue(W'(8'h19), W'(8'h27), 1'b0, 1'b1);
            wait_done(n);
            tick();

            for (int i = 0; i < NRAND; i++) begin
               logic [W-1:0] x, y;
               x = W'($urandom);
               y = W'($urandom);
               wait_idle();
               repeat ($urandom_range(0, 2)) tick();
               issue(x, y, 1'($urandom), 1'($urandom));
            end
            wait_idle();
            repeat (N + 3) tick();
            chk($sformatf("c%0d scoreboard_empty", k), 32'(q.size()), 32'd0);
            cfg_done++;
         end
      end
   endgenerate

   initial begin
      fork
         begin
            wait (cfg_done == NCFG);
         end
         begin
            #500000;
            errors++;
            $display("FAIL global_timeout finished=%0d required=%0d", cfg_done, NCFG);
         end
      join_any
      disable fork;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
- Parametrised, multi-cycle add/subtract unit built from chained one-bit full-adder cells.
- Processes BPC bits per clock, LSB slice first, and keeps the carry in a register between cycles.
- Uses a start/busy/done handshake.
- Serves as the area-economical arithmetic block for MXO2 designs where a WIDTH-bit ripple adder is too large or too slow.

Parameters:
- WIDTH, 8, operand/result width in bits; must be at least 2.
- BPC, 1, bits processed per cycle; must divide WIDTH; NSLICE = WIDTH/BPC.

Ports:
- clk  in  1  system clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request a new operation; sampled only when busy=0
- sub  in  1  0: a+b+cin; 1: a-b (b inverted, carry-in forced 1, cin ignored)
- cin  in  1  carry-in, add mode only
- a  in  WIDTH  operand A, latched on an accepted start
- b  in  WIDTH  operand B, latched on an accepted start
- busy  out  1  high while the operation is in progress
- done  out  1  one-cycle pulse; result outputs updated in the same cycle
- sum  out  WIDTH  result, held until the next done
- cout  out  1  carry out of MSB; in sub mode 1 = no borrow (a>=b unsigned)
- ovf  out  1  signed overflow = carry into MSB XOR carry out of MSB

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; busy=0, done=0, sum=0, cout=0, ovf=0; internal shift registers, slice counter and carry register cleared. Reset overrides start.
- States: IDLE, RUN, DONE.
- IDLE: busy=0, done=0. On start=1, latch a, b^{WIDTH{sub}}, sub; carry_reg <= sub ? 1 : cin; cnt <= 0; go to RUN.
- RUN: busy=1. Each cycle:
  - Feed the low BPC bits of the A/B shift registers plus carry_reg into BPC chained fa cells.
  - Shift the BPC result bits into the result register from the top.
  - Shift the operands right by BPC.
  - carry_reg <= chain carry out; cnt++.
  - On the last slice (cnt = NSLICE-1), capture the carry into the MSB cell (for ovf) and go to DONE.
- DONE: busy=0, done=1 for exactly one cycle. sum, cout and ovf are registered so they show the new values in this cycle. Next state is IDLE, or RUN if start=1 in this cycle (back-to-back accepted; the new operands are latched as in IDLE).
- Latency: start sampled at edge 0, busy high for cycles 1..NSLICE, done high in cycle NSLICE+1. One operation every NSLICE+1 cycles.
- start while busy=1 is ignored and not queued. a/b/sub/cin changes during RUN have no effect.
- sum/cout/ovf keep the previous result throughout RUN and change only on the DONE cycle.
- Mid-operation reset aborts the operation: no done pulse, and outputs return to 0.
- Arithmetic is modulo 2^WIDTH; no sign extension, no saturation.
- Wrap-around examples: FF+01 gives 00 with cout=1; 00-01 gives FF with cout=0.

Decomposition:
- Package serial_addsub_pkg: state enum (IDLE, RUN, DONE) as a 2-bit localparam set; function clog2 for the cnt width (max(1, clog2(NSLICE))).
- Sub-module fa_cell: one-bit full adder, inputs a/b/ci, outputs s/co, purely combinational.
- Instantiate fa_cell BPC times in a generate loop forming the per-cycle ripple chain. The top module holds the FSM, shift registers, carry register and output registers.

Test Plan:
- WIDTH=8, BPC=1: a=FF, b=01, sub=0, cin=0, start at edge 0 -> busy cycles 1-8; done in cycle 9 with sum=00, cout=1, ovf=0.
- Add 7F+01, cin=0 -> sum=80, cout=0, ovf=1. Sub 80-01 -> sum=7F, cout=1, ovf=1. Sub 05-07 -> sum=FE, cout=0, ovf=0.
- Add 10+20 with cin=1 -> sum=31. Sub mode with cin=1 -> cin ignored: 10-05 = 0B.
- start pulsed again in cycle 4 of a run with different operands -> ignored; first result appears unchanged and no second done follows. start held high in the DONE cycle -> second run begins, busy next cycle, done NSLICE+1 cycles later.
- rst asserted in cycle 5 of a run -> next cycle: busy=0, sum=0, cout=0, ovf=0; no done pulse ever; a new start afterwards computes correctly.
- WIDTH=16, BPC=4: a=FFFF, b=0001 -> busy cycles 1-4, done in cycle 5, sum=0000, cout=1. Random regression of 1000 operations against a reference model for BPC in {1,2,4,8}.
